// File: rtl/avmm_reg_file.sv
// Avalon-MM slave register file: byte-writable RW regs, sampled RO words, sticky W1C STATUS with MASK/irq.
// Define AVMM_REG_FILE_RDPIPE_EN to add an output stage on readdata/readdatavalid (read latency 2).
module avmm_reg_file #(
  parameter int          NUM_RW       = 4,
  parameter int          NUM_RO       = 4,
  parameter int          NUM_EV       = 8,
  parameter logic [31:0] UNMAPPED_VAL = 32'hDEADBEEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [31:0]                            address,
  input  logic                                   read,
  input  logic                                   write,
  input  logic [31:0]                            writedata,
  input  logic [3:0]                             byteenable,
  output logic [31:0]                            readdata,
  output logic                                   waitrequest,
  output logic                                   readdatavalid,
  input  logic [32*(NUM_RO > 0 ? NUM_RO : 1)-1:0] ro_in,
  input  logic [NUM_EV-1:0]                      ev_in,
  output logic [32*NUM_RW-1:0]                   rw_out,
  output logic [NUM_RW-1:0]                      wr_strobe,
  output logic                                   irq
);

  localparam int ST_IDX = NUM_RW + NUM_RO;
  localparam int MK_IDX = ST_IDX + 1;

  logic [29:0]                  widx;
  logic [31:0]                  bmask, wmask;
  logic [NUM_RW-1:0][31:0]      rw_q, rw_d;
  logic [NUM_RW-1:0]            strb_q, strb_d;
  logic [NUM_EV-1:0]            status_q, status_d, mask_q, mask_d, clr;
  logic                         irq_q;
  logic [31:0]                  rdata_d, rdata_q;
  logic                         rvld_q;
  logic                         unused_ok;

  assign widx      = address[31:2];
  assign unused_ok = ^address[1:0];
  assign bmask     = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign wmask     = writedata & bmask;

  // Read mux samples pre-write state so a same-cycle read+write returns the old value.
  always_comb begin
    rw_d    = rw_q;
    strb_d  = '0;
    mask_d  = mask_q;
    clr     = '0;
    rdata_d = UNMAPPED_VAL;
    for (int k = 0; k < NUM_RW; k++) begin
      if (widx == 30'(k)) begin
        rdata_d = rw_q[k];
        if (write) begin
          rw_d[k]   = (rw_q[k] & ~bmask) | wmask;
          strb_d[k] = |byteenable;
        end
      end
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (widx == 30'(NUM_RW + k)) rdata_d = ro_in[32*k +: 32];
    end
    if (widx == 30'(ST_IDX)) begin
      rdata_d = 32'(status_q);
      if (write) clr = wmask[NUM_EV-1:0];
    end
    if (widx == 30'(MK_IDX)) begin
      rdata_d = 32'(mask_q);
      if (write) mask_d = (mask_q & ~bmask[NUM_EV-1:0]) | wmask[NUM_EV-1:0];
    end
    status_d = (status_q & ~clr) | ev_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q     <= '0;
      strb_q   <= '0;
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      rvld_q   <= 1'b0;
    end else begin
      rw_q     <= rw_d;
      strb_q   <= strb_d;
      status_q <= status_d;
      mask_q   <= mask_d;
      irq_q    <= |(status_d & mask_d);
      rvld_q   <= read;
      if (read) rdata_q <= rdata_d;
    end
  end

`ifdef AVMM_REG_FILE_RDPIPE_EN
  logic [31:0] rdata2_q;
  logic        rvld2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata2_q <= '0;
      rvld2_q  <= 1'b0;
    end else begin
      rvld2_q <= rvld_q;
      if (rvld_q) rdata2_q <= rdata_q;
    end
  end

  assign readdata      = rdata2_q;
  assign readdatavalid = rvld2_q;
`else
  assign readdata      = rdata_q;
  assign readdatavalid = rvld_q;
`endif

  assign waitrequest = 1'b0;
  assign rw_out      = rw_q;
  assign wr_strobe   = strb_q;
  assign irq         = irq_q;

endmodule

// File: doc/avmm_reg_file.md
# avmm_reg_file

Parametrised Avalon-MM slave register file: the next generation of the team's LED/scratch register bank, sitting behind the vJTAG Avalon-MM master on the board clock domain. It provides NUM_RW byte-writable control registers, NUM_RO read-only status words sampled from fabric, and a sticky write-1-to-clear event register with mask and interrupt output. Reads are registered with a real `readdatavalid` handshake.

## Interface
- NUM_RW, 4: number of 32-bit read/write registers (1..16).
- NUM_RO, 4: number of 32-bit read-only input words (0..16).
- NUM_EV, 8: number of event inputs latched into STATUS (1..32).
- UNMAPPED_VAL, 32'hDEADBEEF: read value for unmapped addresses.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- address  in  32  byte address; word index = address[31:2], address[1:0] ignored.
- read  in  1  read request, accepted every cycle it is high.
- write  in  1  write request, accepted every cycle it is high.
- writedata  in  32  write data.
- byteenable  in  4  per-byte write enable; bit i covers writedata[8i+7:8i].
- readdata  out  32  registered read data, valid when readdatavalid=1.
- waitrequest  out  1  constant 0.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- ro_in  in  32*NUM_RO  read-only words; word k at [32k+31:32k].
- ev_in  in  NUM_EV  event pulses/levels, OR-ed into STATUS each cycle.
- rw_out  out  32*NUM_RW  current RW register contents; reg k at [32k+31:32k].
- wr_strobe  out  NUM_RW  one-cycle pulse, bit k set the cycle after any write (any byteenable bit) to RW reg k.
- irq  out  1  |(STATUS & MASK), driven from registers.

## Operation
- Map (word index i): 0..NUM_RW-1 RW regs; NUM_RW..NUM_RW+NUM_RO-1 RO words; NUM_RW+NUM_RO = STATUS; NUM_RW+NUM_RO+1 = MASK; all other indices unmapped. Defaults: RW 0x00–0x0C, RO 0x10–0x1C, STATUS 0x20, MASK 0x24.
- RW write: each enabled byte updated; disabled bytes hold.
- RO and unmapped writes: ignored, no side effect.
- STATUS (NUM_EV bits, upper bits read 0): next = (STATUS & ~clr) | ev_in, clr = byte-masked writedata on a STATUS write. Set wins over clear in the same cycle for the same bit.
- MASK: byte-writable, NUM_EV bits implemented, upper bits read 0 and ignore writes.
- Read: word selected by address is captured into readdata at the accepting edge; RO words sampled from ro_in that cycle; unmapped returns UNMAPPED_VAL.
- Simultaneous read and write, same address: read returns the pre-write value. Same for STATUS (pre-clear, pre-set value).
- readdata holds its last value when readdatavalid=0.
- Reset values: all RW regs, STATUS, MASK, readdata, readdatavalid, wr_strobe, irq = 0; rw_out = 0.
- Reset mid-read: a read accepted in the reset cycle is dropped (no readdatavalid); reads in flight are flushed.

## Timing
- waitrequest tied 0; back-to-back reads every cycle, one readdatavalid per read, in order.
- Read latency 1 cycle (read at edge N -> readdatavalid/readdata during cycle N+1); 2 cycles with the macro below.
- Write takes effect at accepting edge; rw_out reflects it the following cycle; wr_strobe pulses that same cycle.
- ev_in high at edge N -> STATUS bit set after N -> irq high in cycle N+1 if masked in.
- irq falls in the cycle after a STATUS W1C or MASK clear takes effect.

## Configuration
- AVMM_REG_FILE_RDPIPE_EN: defined -> extra output register stage on readdata/readdatavalid, read latency 2, still one read per cycle, for timing closure at 100 MHz+. Undefined -> latency 1. Write, STATUS and irq timing unchanged in both builds; reset flushes both stages.

## Test plan
- Reset, then read 0x00..0x24 -> all 0 except RO words equal ro_in; read 0x28 -> 0xDEADBEEF, readdatavalid exactly 1 cycle (2 with macro) after each read.
- Write 0x11223344 be=4'b0101 to 0x04 over 0xAABBCCDD -> readback 0xAA22CC44, wr_strobe[1] one pulse, rw_out[63:32] matches.
- Write 0xFFFFFFFF to 0x10 (RO) and 0x40 (unmapped) -> no rw_out/STATUS change, wr_strobe stays 0.
- Pulse ev_in=8'h05, MASK=0x04 -> STATUS reads 0x05, irq=1; write 0x04 to 0x20 -> STATUS 0x01, irq=0; W1C of bit 0 coincident with ev_in[0]=1 -> bit stays 1.
- Read and write 0x08 in the same cycle (old 0x1, new 0x2) -> readdata 0x1, next read 0x2; 16 back-to-back reads -> 16 in-order valids.
- Assert rst during a read burst -> no readdatavalid for flushed reads, all outputs 0 next cycle.
